secuenciador_captura: RTL and testbench
=======================================

SECUENCIADOR_CAPTURA -- requirements
Module: secuenciador_captura

Interface
REQ-001 Parameter NUM_REGS, default 11, number of RTC bytes captured per frame (datos0..datos10 order).
REQ-002 Parameter VBLANK_LINE, default 480, first pixely value counted as vertical blanking.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles waited for rd_ack per read.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pixely  input  10  current VGA line from the VGA sync generator.
REQ-007 rd_req  output  1  read request to the RTC register port.
REQ-008 rd_addr  output  4  RTC byte index being requested (0..NUM_REGS-1).
REQ-009 rd_ack  input  1  RTC port acknowledge; rd_data valid in the same cycle.
REQ-010 rd_data  input  8  BCD byte returned by the RTC port.
REQ-011 datos_o  output  8*NUM_REGS  committed snapshot; byte k at bits [8k+7:8k].
REQ-012 frame_ok  output  1  one-cycle pulse when a new snapshot is committed.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err  output  1  one-cycle pulse when a capture is aborted.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT_ACK, STORE, COMMIT.
REQ-016 Blanking = (pixely >= VBLANK_LINE); vb_start = blanking high this cycle and low in the registered previous cycle.
REQ-017 IDLE -> REQ on vb_start; index counter cleared to 0; otherwise stay in IDLE.
REQ-018 REQ: assert rd_req, drive rd_addr = index, clear timeout counter, go to WAIT_ACK next cycle.
REQ-019 WAIT_ACK: hold rd_req high and rd_addr stable until rd_ack is sampled high; then go to STORE with rd_data latched into staging byte [index].
REQ-020 rd_req SHALL be low in the cycle after rd_ack is sampled; rd_ack while rd_req is low SHALL be ignored.
REQ-021 Timeout counter increments each WAIT_ACK cycle; reaching TIMEOUT without rd_ack aborts.
REQ-022 STORE: if index == NUM_REGS-1 go to COMMIT, else increment index and go to REQ.
REQ-023 COMMIT: copy all staging bytes to datos_o in one cycle, pulse frame_ok, return to IDLE.
REQ-024 Abort: blanking falling low (pixely < VBLANK_LINE) in any non-IDLE state, or timeout, SHALL return to IDLE, pulse err, deassert rd_req, and leave datos_o unchanged.
REQ-025 If abort and vb_start coincide, abort wins; the next capture starts on the following vb_start.
REQ-026 datos_o SHALL change only in COMMIT; partial snapshots are never visible.
REQ-027 Worst-case capture latency: NUM_REGS*(TIMEOUT+3)+1 cycles from vb_start.

Reset
REQ-028 On reset: state IDLE, index 0, rd_req 0, rd_addr 0, datos_o all zero, staging zero, frame_ok 0, err 0, busy 0, previous-blanking flag 0.
REQ-029 Reset mid-capture SHALL discard staging without asserting err.

Configuration
REQ-030 Macro CAPTURA_BCD_CHECK_EN defined: in STORE, a byte with either nibble > 9 SHALL abort per REQ-024.
REQ-031 Macro CAPTURA_BCD_CHECK_EN undefined: bytes stored unchecked; no BCD abort path exists.

Structure
REQ-032 Shared package holds FSM state encoding constants, NUM_REGS default and VBLANK_LINE default.
REQ-033 Single sub-module timeout_contador (load/enable/expired) is natural; everything else flat.

Verification
REQ-034 pixely 479->480, RTC acks after 2 cycles with bytes 0x06,0x07,0x23,0x03,0x05,0x04,0x00,0x01,0x08,0x03,0x02 -> one frame_ok, datos_o[7:0]=0x06, datos_o[87:80]=0x02, rd_addr stepped 0..10.
REQ-035 rd_ack never asserted on index 4 -> err pulse after 15 WAIT_ACK cycles, rd_req low, datos_o equals previous snapshot.
REQ-036 pixely wraps to 0 during index 7 -> err pulse, no frame_ok, datos_o unchanged; next 479->480 capture succeeds.
REQ-037 Spurious rd_ack while in IDLE -> no state change, no staging write.
REQ-038 With CAPTURA_BCD_CHECK_EN, byte 0x3A on index 2 -> err pulse, no commit; without it -> commit with datos_o[23:16]=0x3A.
REQ-039 reset asserted during WAIT_ACK of index 5 -> all outputs zero immediately, no err pulse, IDLE after release.

Source files
------------

// File: rtl/secuenciador_captura_pkg.sv
// secuenciador_captura_pkg: FSM state encoding and default geometry shared by the RTC capture sequencer.
package secuenciador_captura_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, STORE, COMMIT} estado_t;
    localparam int NUM_REGS_DEF    = 11;
    localparam int VBLANK_LINE_DEF = 480;
    localparam int TIMEOUT_DEF     = 15;
    function automatic logic es_bcd(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction
endpackage

// File: rtl/secuenciador_captura_timeout.sv
// timeout_contador: counts WAIT_ACK cycles; expired flags the last cycle allowed before abort.
module timeout_contador #(
    parameter int TIMEOUT = 15
)(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= '0;
        else if (enable) cnt <= cnt + W'(1);
    end
    assign expired = enable && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/secuenciador_captura.sv
// secuenciador_captura: reads NUM_REGS RTC bytes during vertical blanking and commits them atomically.
// Define CAPTURA_BCD_CHECK_EN to abort the capture on any byte that is not valid BCD.
module secuenciador_captura
    import secuenciador_captura_pkg::*;
#(
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int VBLANK_LINE = VBLANK_LINE_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            pixely,
    output logic                  rd_req,
    output logic [3:0]            rd_addr,
    input  logic                  rd_ack,
    input  logic [7:0]            rd_data,
    output logic [8*NUM_REGS-1:0] datos_o,
    output logic                  frame_ok,
    output logic                  busy,
    output logic                  err
);
    estado_t    state, state_n;
    logic [3:0] index;
    logic [7:0] staging [NUM_REGS];
    logic       prev_blank, blanking, vb_start, last, expired, abort;

    assign blanking = pixely >= 10'(VBLANK_LINE);
    assign vb_start = blanking && !prev_blank;
    assign last     = index == 4'(NUM_REGS - 1);
    assign rd_req   = (state == REQ) || (state == WAIT_ACK);
    assign rd_addr  = index;
    assign busy     = state != IDLE;

    timeout_contador #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (state == REQ),
        .enable  (state == WAIT_ACK),
        .expired (expired)
    );

    always_comb begin
        state_n = state;
        abort   = 1'b0;
        case (state)
            IDLE:     state_n = vb_start ? REQ : IDLE;
            REQ:      state_n = WAIT_ACK;
            WAIT_ACK: begin
                state_n = rd_ack ? STORE : WAIT_ACK;
                abort   = !rd_ack && expired;
            end
            STORE:    state_n = last ? COMMIT : REQ;
            COMMIT:   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        // Leaving blanking mid-capture would expose a torn snapshot, so bail out.
        if (state != IDLE && !blanking) abort = 1'b1;
`ifdef CAPTURA_BCD_CHECK_EN
        if (state == STORE && !es_bcd(staging[index])) abort = 1'b1;
`endif
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            index      <= 4'd0;
            prev_blank <= 1'b0;
            datos_o    <= '0;
            frame_ok   <= 1'b0;
            err        <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) staging[k] <= 8'd0;
        end else begin
            state      <= state_n;
            prev_blank <= blanking;
            err        <= abort;
            frame_ok   <= (state == COMMIT) && !abort;
            if (state == IDLE && vb_start) index <= 4'd0;
            if (state == STORE && !abort && !last) index <= index + 4'd1;
            if (state == WAIT_ACK && rd_ack && !abort) staging[index] <= rd_data;
            if (state == COMMIT && !abort)
                for (int k = 0; k < NUM_REGS; k++) datos_o[8*k +: 8] <= staging[k];
        end
    end
endmodule

// File: tb/tb_secuenciador_captura.sv
// tb_secuenciador_captura: randomized RTC responder with a frame-level outcome model.
// Honors CAPTURA_BCD_CHECK_EN when predicting captures that carry non-BCD bytes.
module tb_secuenciador_captura;
    localparam int N     = 11;
    localparam int TO    = 15;
    localparam int BOUND = N * (TO + 3) + 1;

    logic           clk = 1'b0, reset = 1'b1;
    logic [9:0]     pixely = 10'd0;
    logic           rd_ack = 1'b0;
    logic [7:0]     rd_data = 8'd0;
    logic           rd_req, frame_ok, busy, err;
    logic [3:0]     rd_addr;
    logic [8*N-1:0] datos_o;

    secuenciador_captura dut (
        .clk(clk), .reset(reset), .pixely(pixely), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .datos_o(datos_o), .frame_ok(frame_ok),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int             n_checks = 0, n_fail = 0;
    int             lat [16];
    logic [7:0]     mem [16];
    logic [8*N-1:0] snap = '0;
    int             nf, ne, bad_chg, done_at, req_at_err;
    int             req_cnt [16];
    int             addr_log [$];
    bit             rst_hit;

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [7:0] rand_bcd();
        return {4'($urandom_range(9)), 4'($urandom_range(9))};
    endfunction

    function automatic logic [8*N-1:0] packed_mem();
        logic [8*N-1:0] r;
        for (int i = 0; i < N; i++) r[8*i +: 8] = mem[i];
        return r;
    endfunction

    // A frame commits only if every byte is acknowledged within TO waits and blanking holds.
    function automatic bit model_ok(input int drop_at);
        bit ok = (drop_at < 0);
        for (int i = 0; i < N; i++) begin
            if (lat[i] < 1 || lat[i] > TO) ok = 0;
`ifdef CAPTURA_BCD_CHECK_EN
            if (!bcd_ok(mem[i])) ok = 0;
`endif
        end
        return ok;
    endfunction

    task automatic fill(input int lmin, input int lmax);
        for (int i = 0; i < 16; i++) begin
            mem[i] = rand_bcd();
            lat[i] = $urandom_range(lmax, lmin);
        end
    endtask

    task automatic run_frame(input int drop_at, input int rst_at);
        logic [8*N-1:0] prev;
        int wc = 0;
        nf = 0; ne = 0; bad_chg = 0; done_at = -1; req_at_err = 0; rst_hit = 0;
        addr_log.delete();
        for (int i = 0; i < 16; i++) req_cnt[i] = 0;
        @(negedge clk) pixely = 10'd479;
        @(negedge clk);
        @(negedge clk) pixely = 10'd480;
        prev = datos_o;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (frame_ok) nf++;
            if (err) ne++;
            if (err && rd_req) req_at_err++;
            if (datos_o !== prev && !frame_ok) bad_chg++;
            prev = datos_o;
            if (rd_req) req_cnt[rd_addr]++;
            if ((frame_ok || err) && done_at < 0) done_at = c;
            rd_ack  = 1'b0;
            rd_data = 8'($urandom);
            if (rd_req) begin
                if (int'(rd_addr) == rst_at && wc >= 3) begin
                    reset = 1'b1;
                    rst_hit = 1;
                    break;
                end
                if (int'(rd_addr) == drop_at) pixely = 10'd0;
                if (wc == lat[rd_addr]) begin
                    rd_ack  = 1'b1;
                    rd_data = mem[rd_addr];
                    addr_log.push_back(int'(rd_addr));
                    wc = 0;
                end else wc++;
            end else wc = 0;
            if (done_at >= 0 && c > done_at + 4) break;
        end
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rd_req !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
        n_checks++; if (rd_addr !== 4'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_checks++; if (datos_o !== '0) begin n_fail++; $display("FAIL reset_datos: got %h expected 0", datos_o); end
        n_checks++; if (frame_ok !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ok: got %b expected 0", frame_ok); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_capture_nominal();
        logic [7:0] bytes [N] = '{8'h06, 8'h07, 8'h23, 8'h03, 8'h05, 8'h04, 8'h00, 8'h01, 8'h08, 8'h03, 8'h02};
        for (int i = 0; i < N; i++) begin mem[i] = bytes[i]; lat[i] = 2; end
        run_frame(-1, -1);
        snap = packed_mem();
        n_checks++; if (nf !== 1) begin n_fail++; $display("FAIL nominal_frame_ok: got %0d expected 1", nf); end
        n_checks++; if (ne !== 0) begin n_fail++; $display("FAIL nominal_err: got %0d expected 0", ne); end
        n_checks++; if (datos_o[7:0] !== 8'h06) begin n_fail++; $display("FAIL nominal_byte0: got %h expected 06", datos_o[7:0]); end
        n_checks++; if (datos_o[87:80] !== 8'h02) begin n_fail++; $display("FAIL nominal_byte10: got %h expected 02", datos_o[87:80]); end
        n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL nominal_datos: got %h expected %h", datos_o, snap); end
        n_checks++; if (addr_log.size() !== N) begin n_fail++; $display("FAIL nominal_addr_count: got %0d expected %0d", addr_log.size(), N); end
        for (int i = 0; i < addr_log.size(); i++) begin
            n_checks++; if (addr_log[i] !== i) begin n_fail++; $display("FAIL nominal_addr_step: got %0d expected %0d", addr_log[i], i); end
        end
        n_checks++; if (bad_chg !== 0) begin n_fail++; $display("FAIL nominal_partial: got %0d changes expected 0", bad_chg); end
        n_checks++; if (done_at < 0 || done_at > BOUND) begin n_fail++; $display("FAIL nominal_latency: got %0d expected <= %0d", done_at, BOUND); end
    endtask

    task automatic test_spurious_ack();
        int bad = 0;
        pixely = 10'd0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            rd_ack  = 1'b1;
            rd_data = 8'($urandom);
            @(negedge clk);
            if (busy !== 1'b0 || rd_req !== 1'b0 || frame_ok !== 1'b0 || err !== 1'b0) bad++;
        end
        rd_ack = 1'b0;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL spurious_state: got %0d busy cycles expected 0", bad); end
        n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL spurious_datos: got %h expected %h", datos_o, snap); end
    endtask

    task automatic test_timeout();
        fill(1, 4);
        lat[4] = 99;
        run_frame(-1, -1);
        n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d expected 1", ne); end
        n_checks++; if (nf !== 0) begin n_fail++; $display("FAIL timeout_frame_ok: got %0d expected 0", nf); end
        n_checks++; if (req_cnt[4] !== TO + 1) begin n_fail++; $display("FAIL timeout_wait_cycles: got %0d expected %0d", req_cnt[4], TO + 1); end
        n_checks++; if (req_at_err !== 0 || rd_req !== 1'b0) begin n_fail++; $display("FAIL timeout_rd_req: got %0d/%b expected 0/0", req_at_err, rd_req); end
        n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL timeout_datos: got %h expected %h", datos_o, snap); end
    endtask

    task automatic test_timeout_boundary();
        fill(TO, TO);
        run_frame(-1, -1);
        if (model_ok(-1)) snap = packed_mem();
        n_checks++; if (nf !== 1 || ne !== 0) begin n_fail++; $display("FAIL boundary_outcome: got %0d/%0d expected 1/0", nf, ne); end
        n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL boundary_datos: got %h expected %h", datos_o, snap); end
        n_checks++; if (done_at < 0 || done_at > BOUND) begin n_fail++; $display("FAIL boundary_latency: got %0d expected <= %0d", done_at, BOUND); end
    endtask

    task automatic test_blank_drop();
        fill(1, 3);
        run_frame(7, -1);
        n_checks++; if (ne !== 1 || nf !== 0) begin n_fail++; $display("FAIL drop_outcome: got %0d/%0d expected err 1 frame 0", ne, nf); end
        n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL drop_datos: got %h expected %h", datos_o, snap); end
        n_checks++; if (bad_chg !== 0) begin n_fail++; $display("FAIL drop_partial: got %0d changes expected 0", bad_chg); end
        fill(1, 3);
        run_frame(-1, -1);
        snap = packed_mem();
        n_checks++; if (nf !== 1 || ne !== 0) begin n_fail++; $display("FAIL drop_recover: got %0d/%0d expected 1/0", nf, ne); end
        n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL drop_recover_datos: got %h expected %h", datos_o, snap); end
    endtask

    task automatic test_bcd();
        fill(1, 3);
        mem[2] = 8'h3A;
        run_frame(-1, -1);
`ifdef CAPTURA_BCD_CHECK_EN
        n_checks++; if (ne !== 1 || nf !== 0) begin n_fail++; $display("FAIL bcd_abort: got err %0d frame %0d expected 1/0", ne, nf); end
        n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL bcd_datos: got %h expected %h", datos_o, snap); end
`else
        snap = packed_mem();
        n_checks++; if (nf !== 1 || ne !== 0) begin n_fail++; $display("FAIL bcd_commit: got frame %0d err %0d expected 1/0", nf, ne); end
        n_checks++; if (datos_o[23:16] !== 8'h3A) begin n_fail++; $display("FAIL bcd_byte2: got %h expected 3a", datos_o[23:16]); end
`endif
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int  drop;
            bit  ok;
            fill(1, TO);
            if ($urandom_range(3) == 0) lat[$urandom_range(N - 1)] = TO + 1;
            if ($urandom_range(3) == 0) mem[$urandom_range(N - 1)] = 8'($urandom);
            drop = ($urandom_range(3) == 0) ? int'($urandom_range(N - 1)) : -1;
            ok = model_ok(drop);
            run_frame(drop, -1);
            if (ok) snap = packed_mem();
            n_checks++; if (nf !== int'(ok) || ne !== int'(!ok)) begin n_fail++; $display("FAIL random_outcome[%0d]: got frame %0d err %0d expected %0d/%0d", f, nf, ne, ok, !ok); end
            n_checks++; if (datos_o !== snap) begin n_fail++; $display("FAIL random_datos[%0d]: got %h expected %h", f, datos_o, snap); end
            n_checks++; if (bad_chg !== 0) begin n_fail++; $display("FAIL random_partial[%0d]: got %0d expected 0", f, bad_chg); end
        end
    endtask

    task automatic test_reset_mid();
        int errs = 0, busy_seen = 0;
        fill(1, 3);
        lat[5] = 99;
        run_frame(-1, 5);
        n_checks++; if (rst_hit !== 1'b1) begin n_fail++; $display("FAIL rstmid_reached: got %b expected 1", rst_hit); end
        #1;
        snap = '0;
        n_checks++; if (rd_req !== 1'b0 || rd_addr !== 4'd0) begin n_fail++; $display("FAIL rstmid_port: got %b/%0d expected 0/0", rd_req, rd_addr); end
        n_checks++; if (datos_o !== '0) begin n_fail++; $display("FAIL rstmid_datos: got %h expected 0", datos_o); end
        n_checks++; if (busy !== 1'b0 || err !== 1'b0 || frame_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got busy %b err %b frame %b expected 0", busy, err, frame_ok); end
        pixely = 10'd0;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (err) errs++;
            if (busy) busy_seen++;
        end
        n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL rstmid_err: got %0d pulses expected 0", errs); end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL rstmid_idle: got %0d busy cycles expected 0", busy_seen); end
    endtask

    initial begin
        test_reset();
        test_capture_nominal();
        test_spurious_ack();
        test_timeout();
        test_timeout_boundary();
        test_blank_drop();
        test_bcd();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
